// File: rtl/clk_div_pkg.sv
`default_nettype none
// +-------------------------------------------------------------------+
// | clk_div_pkg: shared state encoding and limits for clk_div_mc      |
// | Rev 1.0                                                           |
// +-------------------------------------------------------------------+
package clk_div_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_HIGH   = 2'b01,
        ST_LOW    = 2'b10,
        ST_BYPASS = 2'b11
    } div_state_t;

    localparam int MIN_DIV_RATIO = 2;

endpackage : clk_div_pkg
`default_nettype wire

// File: rtl/clk_div_ch.sv
`default_nettype none
// +-------------------------------------------------------------------+
// | clk_div_ch: one glitch-free programmable divider channel          |
// | Optional macro: ODD_DUTY50_EN (falling-edge flop, 50% odd duty)   |
// | Rev 1.0                                                           |
// +-------------------------------------------------------------------+
module clk_div_ch
    import clk_div_pkg::*;
#(
    parameter int RATIO_WIDTH = 8
) (
    input  logic                   i_ref_clk,
    input  logic                   i_rst,
    input  logic                   i_clk_en,
    input  logic [RATIO_WIDTH-1:0] i_div_ratio,
    output logic                   o_div_clk,
    output logic                   o_period_tick,
    output logic                   o_busy
);

    localparam logic [RATIO_WIDTH-1:0] c_one     = RATIO_WIDTH'(1);
    localparam logic [RATIO_WIDTH-1:0] c_min_div = RATIO_WIDTH'(MIN_DIV_RATIO);

    div_state_t             r_state;
    div_state_t             w_nxt_state;
    logic [RATIO_WIDTH-1:0] r_cnt;
    logic [RATIO_WIDTH-1:0] w_nxt_cnt;
    logic [RATIO_WIDTH-1:0] r_ratio;
    logic [RATIO_WIDTH-1:0] w_nxt_ratio;
    logic [RATIO_WIDTH-1:0] w_high_cnt;
    logic [RATIO_WIDTH-1:0] w_low_cnt;
    logic                   w_high_last;
    logic                   w_period_end;
    logic                   w_sample;
    logic                   r_high_pos;
    logic                   r_byp;
    logic                   w_core_clk;

    // H and L are both >= 1 whenever a ratio >= 2 is active, so the -1 never wraps
    assign w_high_cnt   = r_ratio >> 1;
    assign w_low_cnt    = r_ratio - w_high_cnt;
    assign w_high_last  = (r_cnt == w_high_cnt - c_one);
    assign w_period_end = (r_state == ST_LOW) && (r_cnt == w_low_cnt - c_one);
    assign w_sample     = (r_state == ST_IDLE) || (r_state == ST_BYPASS) || w_period_end;

    always_comb begin
        w_nxt_state = r_state;
        w_nxt_cnt   = r_cnt;
        w_nxt_ratio = r_ratio;
        if (w_sample) begin
            w_nxt_ratio = i_div_ratio;
            w_nxt_cnt   = '0;
            if (!i_clk_en) begin
                w_nxt_state = ST_IDLE;
            end else if (i_div_ratio >= c_min_div) begin
                w_nxt_state = ST_HIGH;
            end else begin
                w_nxt_state = ST_BYPASS;
            end
        end else begin
            case (r_state)
                ST_HIGH: begin
                    if (w_high_last) begin
                        w_nxt_cnt   = '0;
                        w_nxt_state = ST_LOW;
                    end else begin
                        w_nxt_cnt = r_cnt + c_one;
                    end
                end
                ST_LOW:  w_nxt_cnt = r_cnt + c_one;
                default: w_nxt_cnt = r_cnt;
            endcase
        end
    end

    always_ff @(posedge i_ref_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_ratio    <= '0;
            r_high_pos <= 1'b0;
            r_byp      <= 1'b0;
        end else begin
            r_state    <= w_nxt_state;
            r_cnt      <= w_nxt_cnt;
            r_ratio    <= w_nxt_ratio;
            r_high_pos <= (w_nxt_state == ST_HIGH);
            r_byp      <= (w_nxt_state == ST_BYPASS);
        end
    end

`ifdef ODD_DUTY50_EN
    logic r_high_neg;

    // Delayed copy of the high phase, half a ref cycle late, for odd ratios only
    always_ff @(negedge i_ref_clk or posedge i_rst) begin
        if (i_rst) begin
            r_high_neg <= 1'b0;
        end else begin
            r_high_neg <= r_high_pos & r_ratio[0];
        end
    end

    assign w_core_clk = r_high_pos | r_high_neg;
`else
    assign w_core_clk = r_high_pos;
`endif

    // Select is a flop updated on the ref rising edge, so switching never cuts a pulse short
    assign o_div_clk     = r_byp ? i_ref_clk : w_core_clk;
    assign o_period_tick = (r_state == ST_BYPASS) || w_period_end;
    assign o_busy        = (r_state != ST_IDLE);

endmodule : clk_div_ch
`default_nettype wire

// File: rtl/clk_div_mc.sv
`default_nettype none
// +-------------------------------------------------------------------+
// | clk_div_mc: NUM_CH independent programmable clock dividers        |
// | Optional macro: ODD_DUTY50_EN (passed through to every channel)   |
// | Rev 1.0                                                           |
// +-------------------------------------------------------------------+
module clk_div_mc #(
    parameter int NUM_CH      = 2,
    parameter int RATIO_WIDTH = 8
) (
    input  logic                          i_ref_clk,
    input  logic                          i_rst,
    input  logic [NUM_CH-1:0]             i_clk_en,
    input  logic [NUM_CH*RATIO_WIDTH-1:0] i_div_ratio,
    output logic [NUM_CH-1:0]             o_div_clk,
    output logic [NUM_CH-1:0]             o_period_tick,
    output logic [NUM_CH-1:0]             o_busy
);

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        clk_div_ch #(
            .RATIO_WIDTH(RATIO_WIDTH)
        ) u_ch (
            .i_ref_clk    (i_ref_clk),
            .i_rst        (i_rst),
            .i_clk_en     (i_clk_en[k]),
            .i_div_ratio  (i_div_ratio[k*RATIO_WIDTH +: RATIO_WIDTH]),
            .o_div_clk    (o_div_clk[k]),
            .o_period_tick(o_period_tick[k]),
            .o_busy       (o_busy[k])
        );
    end

endmodule : clk_div_mc
`default_nettype wire

// File: tb/tb_clk_div_mc.sv
`default_nettype none
// +-------------------------------------------------------------------+
// | tb_clk_div_mc: randomized bench with a period-position model      |
// | Rev 1.0                                                           |
// +-------------------------------------------------------------------+
module tb_clk_div_mc;

    localparam int NUM_CH = 2;
    localparam int RW     = 8;

    logic                 clk;
    logic                 rst;
    logic [NUM_CH-1:0]    en;
    logic [NUM_CH*RW-1:0] ratio;
    logic [NUM_CH-1:0]    div_clk;
    logic [NUM_CH-1:0]    tick;
    logic [NUM_CH-1:0]    busy;

    int total_cnt = 0;
    int pass_cnt  = 0;

    // model: mode 0 = stopped, 1 = dividing, 2 = pass-through; pos = ref cycle within period
    int m_mode [NUM_CH];
    int m_n    [NUM_CH];
    int m_pos  [NUM_CH];

    clk_div_mc #(
        .NUM_CH     (NUM_CH),
        .RATIO_WIDTH(RW)
    ) dut (
        .i_ref_clk    (clk),
        .i_rst        (rst),
        .i_clk_en     (en),
        .i_div_ratio  (ratio),
        .o_div_clk    (div_clk),
        .o_period_tick(tick),
        .o_busy       (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    function automatic logic exp_clk(input int k, input bit hi_phase);
        int h;
        h = m_n[k] / 2;
        if (m_mode[k] == 0) return 1'b0;
        if (m_mode[k] == 2) return hi_phase;
        if (m_pos[k] < h) return 1'b1;
`ifdef ODD_DUTY50_EN
        if (hi_phase && (m_n[k] % 2 == 1) && (m_pos[k] == h)) return 1'b1;
`endif
        return 1'b0;
    endfunction

    // Reference model: advances on every ref rising edge
    initial begin
        for (int k = 0; k < NUM_CH; k++) begin
            m_mode[k] = 0; m_n[k] = 0; m_pos[k] = 0;
        end
        forever begin
            @(posedge clk or posedge rst);
            for (int k = 0; k < NUM_CH; k++) begin
                int r;
                r = int'(ratio[k*RW +: RW]);
                if (rst) begin
                    m_mode[k] = 0; m_n[k] = 0; m_pos[k] = 0;
                end else if (m_mode[k] != 1 || m_pos[k] == m_n[k] - 1) begin
                    m_n[k]   = r;
                    m_pos[k] = 0;
                    if (!en[k])      m_mode[k] = 0;
                    else if (r >= 2) m_mode[k] = 1;
                    else             m_mode[k] = 2;
                end else begin
                    m_pos[k]++;
                end
            end
        end
    end

    task automatic compare(input bit hi_phase);
        logic [NUM_CH-1:0] e_clk, e_tick, e_busy;
        for (int k = 0; k < NUM_CH; k++) begin
            e_clk[k]  = exp_clk(k, hi_phase);
            e_tick[k] = (m_mode[k] == 2) || (m_mode[k] == 1 && m_pos[k] == m_n[k] - 1);
            e_busy[k] = (m_mode[k] != 0);
        end
        check(hi_phase ? "div_clk_hi" : "div_clk_lo", 32'(div_clk), 32'(e_clk));
        check("period_tick", 32'(tick), 32'(e_tick));
        check("busy", 32'(busy), 32'(e_busy));
    endtask

    // Single compare process: once in each half of every ref cycle
    initial begin
        forever begin
            @(posedge clk); #1; compare(1'b1);
            @(negedge clk); #1; compare(1'b0);
        end
    end

    task automatic drive_slot();
        @(negedge clk); #2;
    endtask

    task automatic set_ch(input int k, input bit e, input int r);
        en[k] = e;
        ratio[k*RW +: RW] = RW'(r);
    endtask

    task automatic wait_tick0();
        int n;
        n = 0;
        do begin
            @(posedge clk); #1; n++;
        end while (!tick[0] && n < 300);
        if (!tick[0]) check("wait_tick_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        logic [7:0] pat_clk, pat_tick;
        int acc_hi, acc_tick, n;

        rst = 1'b1; en = '0; ratio = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_div_clk", 32'(div_clk), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_tick", 32'(tick), 32'd0);
        drive_slot();
        rst = 1'b0;

        // N=4: 1,1,0,0 with tick on the second low cycle
        drive_slot();
        set_ch(0, 1'b1, 4);
        for (int i = 7; i >= 0; i--) begin
            @(posedge clk); #1;
            pat_clk[i]  = div_clk[0];
            pat_tick[i] = tick[0];
        end
        check("n4_clk_pattern", 32'(pat_clk), 32'h000000CC);
        check("n4_tick_pattern", 32'(pat_tick), 32'h00000011);

        // N=7: high half-cycles over one full period
        drive_slot();
        set_ch(0, 1'b1, 7);
        wait_tick0();
        acc_hi = 0; acc_tick = 0;
        for (int i = 0; i < 7; i++) begin
            @(posedge clk); #1; acc_hi += int'(div_clk[0]); acc_tick += int'(tick[0]);
            @(negedge clk); #1; acc_hi += int'(div_clk[0]);
        end
`ifdef ODD_DUTY50_EN
        check("n7_high_halves", 32'(acc_hi), 32'd7);
`else
        check("n7_high_halves", 32'(acc_hi), 32'd6);
`endif
        check("n7_ticks", 32'(acc_tick), 32'd1);

        // N=8: drop enable in the second low cycle, period still completes
        drive_slot();
        set_ch(0, 1'b1, 8);
        wait_tick0();
        wait_tick0();
        repeat (6) @(posedge clk);
        drive_slot();
        set_ch(0, 1'b0, 8);
        n = 0;
        do begin
            @(posedge clk); #1; n++;
        end while (busy[0] && n < 20);
        check("n8_cycles_to_idle", 32'(n), 32'd3);
        check("n8_idle_clk", 32'(div_clk[0]), 32'd0);
        drive_slot();
        set_ch(0, 1'b1, 8);
        @(posedge clk); #1;
        check("reenable_high", 32'(div_clk[0]), 32'd1);

        // Bypass: ratio 1 then 0, output follows ref, tick held high
        drive_slot();
        set_ch(0, 1'b1, 1);
        wait_tick0();
        repeat (2) @(posedge clk);
        #1;
        check("bypass_hi", 32'(div_clk[0]), 32'd1);
        check("bypass_tick", 32'(tick[0]), 32'd1);
        @(negedge clk); #1;
        check("bypass_lo", 32'(div_clk[0]), 32'd0);
        drive_slot();
        set_ch(0, 1'b1, 0);
        repeat (4) @(posedge clk);
        drive_slot();
        set_ch(0, 1'b1, 2);
        repeat (8) @(posedge clk);

        // Mid-run asynchronous reset with ch0 N=3, ch1 N=255
        drive_slot();
        set_ch(0, 1'b1, 3);
        set_ch(1, 1'b1, 255);
        repeat (300) @(posedge clk);
        n = 0;
        do begin
            @(posedge clk); #1; n++;
        end while (div_clk == '0 && n < 300);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_clk", 32'(div_clk), 32'd0);
        check("async_rst_busy", 32'(busy), 32'd0);
        drive_slot();
        rst = 1'b0;
        repeat (600) @(posedge clk);

        // Randomized ratio/enable changes on both channels
        for (int seg = 0; seg < 60; seg++) begin
            drive_slot();
            for (int k = 0; k < NUM_CH; k++) begin
                int r;
                if ($urandom_range(0, 2) != 0) begin
                    case ($urandom_range(0, 7))
                        0:       r = 0;
                        1:       r = 1;
                        2:       r = 2;
                        3:       r = 3;
                        4:       r = int'($urandom_range(4, 16));
                        5:       r = 255;
                        6:       r = int'($urandom_range(2, 40));
                        default: r = int'($urandom_range(0, 255));
                    endcase
                    set_ch(k, ($urandom_range(0, 5) != 0), r);
                end
            end
            repeat ($urandom_range(1, 60)) @(posedge clk);
        end

        repeat (10) @(posedge clk);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule : tb_clk_div_mc
`default_nettype wire
